xmem_pingpong_feeder: RTL and testbench
=======================================

// Module: xmem_pingpong_feeder
// PURPOSE
//  Writer/server end of the image interface that the accelerator reads through counter1/xdata.
//  The core (picoRV32 side) fills one of two image banks with a valid/ready write stream.
//  The accelerator reads the other bank by word address, which keeps the combinational xmem contract.
//  Loading image N+1 overlaps with inference on image N; start/done pulses sequence each image.
// PARAMETERS
//  DEPTH   784  words per image bank (28x28 MNIST pixels)
//  DATA_W  32   pixel word width
//  ADDR_W  10   write-address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk         in   1       clock; all state updates on the rising edge
//  reset       in   1       asynchronous, active-high reset
//  wr_valid    in   1       write beat offered
//  wr_ready    out  1       fill bank can accept a beat
//  wr_addr     in   ADDR_W  word address within the fill bank
//  wr_data     in   DATA_W  pixel word
//  wr_last     in   1       this beat completes the image; commits the fill bank
//  ctr1        in   32      accelerator read address (its counter1)
//  xdata       out  DATA_W  pixel at ctr1 from the read bank; combinational
//  img_valid   out  1       read bank holds a committed image being served
//  start       out  1       1-cycle pulse: a new image is available to the accelerator
//  acc_done    in   1       1-cycle pulse: accelerator is finished with the current image
//  full_cnt    out  2       committed, unreleased banks (0..2)
//  served_cnt  out  16      images released since reset; wraps at 65535 -> 0
// BEHAVIOUR
//  Reset values (async): full_cnt=0, fill_ptr=0, rd_ptr=0, state=IDLE, start=0, img_valid=0, served_cnt=0.
//   Memory contents are not reset. Reset mid-fill or mid-run discards all images.
//  Write side:
//   - wr_ready = (full_cnt != 2); it is a combinational function of registered state only.
//   - A beat is accepted when wr_valid && wr_ready; mem[fill_ptr][wr_addr] <= wr_data.
//   - If wr_addr >= DEPTH, the beat is still accepted, but the data is dropped.
//   - An accepted beat with wr_last toggles fill_ptr and increments full_cnt on the same edge.
//   - wr_last without acceptance has no effect.
//  Read FSM, states IDLE and RUN:
//   - IDLE, full_cnt>0: next state RUN; start=1 for exactly that transition cycle (registered).
//     img_valid=1 from the first RUN cycle.
//   - RUN: xdata = mem[rd_ptr][ctr1] if ctr1 < DEPTH, else 0. In IDLE, xdata = 0.
//   - RUN, acc_done=1: rd_ptr toggles, full_cnt decrements, served_cnt increments.
//     Next state is IDLE and img_valid drops on the next cycle.
//   - acc_done in IDLE is ignored. The earliest next start is the cycle after IDLE is re-entered,
//     so there are at least 2 cycles from a done to the next start.
//  Simultaneous events:
//   - Commit and release on the same edge: full_cnt unchanged; both pointers toggle.
//   - A commit at full_cnt=2 cannot occur, because wr_ready=0.
//   - A write to the fill bank never alters the read bank, including while full_cnt=1 and in RUN.
//  Bank ownership invariant: fill_ptr != rd_ptr whenever full_cnt=1 and state=RUN.
//  Read latency 0 (combinational). Write-to-readable latency: commit edge + 1 cycle to start.
// TESTING
//  1. Reset, then write 784 beats, data=addr, last on addr 783.
//     -> full_cnt=1; start pulses 1 cycle; in RUN, ctr1=5 gives xdata=5 and ctr1=783 gives 783.
//  2. During RUN on image A (data=addr), fill image B (data=addr+1000) and commit.
//     -> xdata still =ctr1 and full_cnt=2, wr_ready=0.
//     -> After acc_done: start pulses, and ctr1=5 gives xdata=1005.
//  3. Hold wr_valid with full_cnt=2 -> no beat accepted.
//     -> acc_done frees a bank; wr_ready rises on the cycle after the edge.
//  4. Commit and acc_done on the same edge -> full_cnt unchanged (1); served_cnt +1; ptrs both toggle.
//  5. wr_addr=900 beat -> accepted, no memory change; ctr1=900 in RUN gives xdata=0.
//     acc_done in IDLE -> ignored (served_cnt unchanged).
//  6. Assert reset mid-RUN with full_cnt=2.
//     -> All outputs go to reset values immediately; no start until a new commit.

Source files
------------

// File: rtl/xmem_pingpong_feeder.sv
// Ping-pong image buffer between the core-side write stream and the accelerator's
// combinational word-address read port. One bank fills while the other is served.
module xmem_pingpong_feeder #(
   parameter int unsigned DEPTH  = 784,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_last,
   input  logic [31:0]       ctr1,
   output logic [DATA_W-1:0] xdata,
   output logic              img_valid,
   output logic              start,
   input  logic              acc_done,
   output logic [1:0]        full_cnt,
   output logic [15:0]       served_cnt
);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e      state_q, state_d;
   logic        fill_ptr_q, fill_ptr_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic [1:0]  full_cnt_q, full_cnt_d;
   logic [15:0] served_cnt_q, served_cnt_d;
   logic        start_q, start_d;
   logic        img_valid_q, img_valid_d;

   logic [DATA_W-1:0] mem [2][DEPTH];

   logic wr_accept;
   logic commit;
   logic release_bank;

   // Ready depends only on registered state, so the writer never sees a combinational loop.
   assign wr_ready     = (full_cnt_q != 2'd2);
   assign wr_accept    = wr_valid && wr_ready;
   assign commit       = wr_accept && wr_last;
   assign release_bank = (state_q == StRun) && acc_done;

   // Next-state for the bank pointers, occupancy count and read FSM.
   always_comb begin
      state_d      = state_q;
      fill_ptr_d   = fill_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      full_cnt_d   = full_cnt_q;
      served_cnt_d = served_cnt_q;
      start_d      = 1'b0;
      img_valid_d  = img_valid_q;

      if (commit) begin
         fill_ptr_d = ~fill_ptr_q;
      end
      if (release_bank) begin
         rd_ptr_d     = ~rd_ptr_q;
         served_cnt_d = served_cnt_q + 16'd1;
      end

      // Commit and release on the same edge leave the count unchanged.
      unique case ({commit, release_bank})
         2'b10:   full_cnt_d = full_cnt_q + 2'd1;
         2'b01:   full_cnt_d = full_cnt_q - 2'd1;
         default: full_cnt_d = full_cnt_q;
      endcase

      unique case (state_q)
         StIdle: begin
            if (full_cnt_q != 2'd0) begin
               state_d     = StRun;
               start_d     = 1'b1;
               img_valid_d = 1'b1;
            end
         end
         StRun: begin
            if (acc_done) begin
               state_d     = StIdle;
               img_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Control state; reset discards every committed or partially written image.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StIdle;
         fill_ptr_q   <= 1'b0;
         rd_ptr_q     <= 1'b0;
         full_cnt_q   <= 2'd0;
         served_cnt_q <= 16'd0;
         start_q      <= 1'b0;
         img_valid_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         fill_ptr_q   <= fill_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         full_cnt_q   <= full_cnt_d;
         served_cnt_q <= served_cnt_d;
         start_q      <= start_d;
         img_valid_q  <= img_valid_d;
      end
   end

   // Bank storage is not reset; out-of-range beats are accepted but dropped.
   always_ff @(posedge clk) begin
      if (wr_accept && (32'(wr_addr) < DEPTH)) begin
         mem[fill_ptr_q][wr_addr] <= wr_data;
      end
   end

   // Combinational read port; zero when idle or out of range.
   always_comb begin
      xdata = '0;
      if ((state_q == StRun) && (ctr1 < DEPTH)) begin
         xdata = mem[rd_ptr_q][ctr1[ADDR_W-1:0]];
      end
   end

   assign start      = start_q;
   assign img_valid  = img_valid_q;
   assign full_cnt   = full_cnt_q;
   assign served_cnt = served_cnt_q;

endmodule

// File: tb/tb_xmem_pingpong_feeder.sv
// Scenario bench for the ping-pong image feeder; expected pixels are queued when an image is
// written and popped when that image is served.
module tb_xmem_pingpong_feeder;

   localparam int unsigned DEPTH  = 784;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 10;

   logic              clk = 1'b0;
   logic              reset;
   logic              wr_valid;
   logic              wr_ready;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_last;
   logic [31:0]       ctr1;
   logic [DATA_W-1:0] xdata;
   logic              img_valid;
   logic              start;
   logic              acc_done;
   logic [1:0]        full_cnt;
   logic [15:0]       served_cnt;

   typedef struct {
      int unsigned       addr;
      logic [DATA_W-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   xmem_pingpong_feeder #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_valid   (wr_valid),
      .wr_ready   (wr_ready),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .wr_last    (wr_last),
      .ctr1       (ctr1),
      .xdata      (xdata),
      .img_valid  (img_valid),
      .start      (start),
      .acc_done   (acc_done),
      .full_cnt   (full_cnt),
      .served_cnt (served_cnt)
   );

   always #50 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_status(input string name, input logic [1:0] e_full, input logic [15:0] e_srv,
                             input logic e_start, input logic e_iv);
      n_checks++;
      if ({full_cnt, served_cnt, start, img_valid} !== {e_full, e_srv, e_start, e_iv}) begin
         n_fail++;
         $display("FAIL %s: full=%0d served=%0d start=%b img_valid=%b, want %0d %0d %b %b",
                  name, full_cnt, served_cnt, start, img_valid, e_full, e_srv, e_start, e_iv);
      end
   endtask

   task automatic chk_xdata(input string name, input int unsigned addr, input logic [31:0] exp);
      ctr1 = addr;
      #1;
      n_checks++;
      if (xdata !== exp) begin
         n_fail++;
         $display("FAIL %s: ctr1=%0d xdata=%0d, want %0d", name, addr, xdata, exp);
      end
   endtask

   // Write a full image (data = addr + offset); optionally pulse acc_done on the commit edge.
   task automatic write_image(input int unsigned offset, input logic done_on_last);
      int bad_ready = 0;
      for (int a = 0; a < int'(DEPTH); a++) begin
         wr_valid = 1'b1;
         wr_addr  = ADDR_W'(a);
         wr_data  = DATA_W'(a + int'(offset));
         wr_last  = (a == int'(DEPTH) - 1);
         acc_done = done_on_last && (a == int'(DEPTH) - 1);
         if (wr_ready !== 1'b1) bad_ready++;
         tick();
      end
      wr_valid = 1'b0;
      wr_last  = 1'b0;
      acc_done = 1'b0;
      n_checks++;
      if (bad_ready != 0) begin
         n_fail++;
         $display("FAIL wr_ready_during_fill: %0d beats saw wr_ready=0, want 0", bad_ready);
      end
      sb.push_back('{addr: 5, data: DATA_W'(5 + offset)});
      sb.push_back('{addr: 10, data: DATA_W'(10 + offset)});
      sb.push_back('{addr: DEPTH - 1, data: DATA_W'(DEPTH - 1 + offset)});
   endtask

   // Pop the oldest image's probes and compare against the served bank.
   task automatic serve_image(input string name);
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         n_checks++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty, want entry", name);
         end else begin
            e    = sb.pop_front();
            ctr1 = e.addr;
            #1;
            if (xdata !== e.data) begin
               n_fail++;
               $display("FAIL %s: ctr1=%0d xdata=%0d, want %0d", name, e.addr, xdata, e.data);
            end
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; wr_last = 1'b0;
      ctr1 = 32'd5; acc_done = 1'b0;
      tick(); tick();
      chk_status("reset_state", 2'd0, 16'd0, 1'b0, 1'b0);
      chk_xdata("reset_xdata", 5, 32'd0);
      n_checks++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_wr_ready: got %b, want 1", wr_ready);
      end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_fill_and_start();
      write_image(0, 1'b0);
      chk_status("after_commit_a", 2'd1, 16'd0, 1'b0, 1'b0);
      tick();
      chk_status("start_a", 2'd1, 16'd0, 1'b1, 1'b1);
      serve_image("serve_a");
      tick();
      chk_status("start_pulse_ends", 2'd1, 16'd0, 1'b0, 1'b1);
   endtask

   task automatic test_overlap_and_backpressure();
      write_image(1000, 1'b0);
      chk_status("full_two", 2'd2, 16'd0, 1'b0, 1'b1);
      chk_xdata("read_bank_untouched", 5, 32'd5);
      // Hold a beat against a full buffer.
      wr_valid = 1'b1; wr_addr = 10'd10; wr_data = 32'hBAD; wr_last = 1'b0;
      n_checks++;
      if (wr_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_ready_full: got %b, want 0", wr_ready);
      end
      tick(); tick();
      chk_status("held_no_accept", 2'd2, 16'd0, 1'b0, 1'b1);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      n_checks++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready_after_done: got %b, want 1", wr_ready);
      end
      chk_status("release_a", 2'd1, 16'd1, 1'b0, 1'b0);
      chk_xdata("idle_xdata", 5, 32'd0);
      tick();
      wr_valid = 1'b0;
      chk_status("start_b", 2'd1, 16'd1, 1'b1, 1'b1);
      serve_image("serve_b");
   endtask

   task automatic test_back_to_back();
      write_image(2000, 1'b1);
      chk_status("commit_and_release", 2'd1, 16'd2, 1'b0, 1'b0);
      tick();
      chk_status("start_c", 2'd1, 16'd2, 1'b1, 1'b1);
      serve_image("serve_c");
   endtask

   task automatic test_out_of_range();
      wr_valid = 1'b1; wr_addr = 10'd900; wr_data = 32'h1234; wr_last = 1'b0;
      n_checks++;
      if (wr_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL wr_ready_oor: got %b, want 1", wr_ready);
      end
      tick();
      wr_valid = 1'b0;
      chk_xdata("oor_read", 900, 32'd0);
      chk_xdata("after_oor_write", 5, 32'd2005);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      chk_status("release_c", 2'd0, 16'd3, 1'b0, 1'b0);
      tick();
      chk_status("stay_idle", 2'd0, 16'd3, 1'b0, 1'b0);
      chk_xdata("idle_empty_xdata", 5, 32'd0);
      acc_done = 1'b1;
      tick();
      acc_done = 1'b0;
      tick();
      chk_status("done_in_idle", 2'd0, 16'd3, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid_run();
      write_image(3000, 1'b0);
      tick();
      chk_status("start_d", 2'd1, 16'd3, 1'b1, 1'b1);
      serve_image("serve_d");
      write_image(4000, 1'b0);
      chk_status("full_before_reset", 2'd2, 16'd3, 1'b0, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      chk_status("async_reset", 2'd0, 16'd0, 1'b0, 1'b0);
      chk_xdata("async_reset_xdata", 5, 32'd0);
      sb.delete();
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick();
      chk_status("no_start_after_reset", 2'd0, 16'd0, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_fill_and_start();
      test_overlap_and_backpressure();
      test_back_to_back();
      test_out_of_range();
      test_reset_mid_run();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
